// File: rtl/iob_timer_alarm_pkg.sv
// Shared types and default sizing for the timer compare/alarm stage.
package iob_timer_alarm_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_MISS_W = 8;
    localparam int unsigned TIME_W     = 2 * DEF_DATA_W;
    localparam int unsigned MISS_MAX   = (1 << DEF_MISS_W) - 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StFired = 2'd2
    } state_t;

endpackage

// File: rtl/iob_timer_alarm_cmp.sv
// Signed-difference "time has reached compare" detector; tolerant of time wrap-around.
module iob_timer_alarm_cmp #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] time_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             reached
);

    logic [WIDTH-1:0] diff;

    // Modular difference; non-negative as a signed value means time is at or past compare.
    always_comb begin
        diff    = time_val - cmp_val;
        reached = ~diff[WIDTH-1];
    end

endmodule

// File: rtl/iob_timer_alarm.sv
// Compare/alarm stage: one-shot or periodic alarm against the free-running timer,
// with a level interrupt and a saturating missed-event counter.
module iob_timer_alarm
    import iob_timer_alarm_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MISS_W = DEF_MISS_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic [2*DATA_W-1:0] time_i,
    input  logic [DATA_W-1:0]   cmp_lo_i,
    input  logic                cmp_lo_we_i,
    input  logic [DATA_W-1:0]   cmp_hi_i,
    input  logic                cmp_hi_we_i,
    input  logic [2*DATA_W-1:0] period_i,
    input  logic                periodic_i,
    input  logic                en_i,
    input  logic                ack_i,
    output logic                irq_o,
    output logic                armed_o,
    output logic [2*DATA_W-1:0] cmp_o,
    output logic [MISS_W-1:0]   miss_cnt_o
);

    localparam int unsigned TW = 2 * DATA_W;
    localparam logic [MISS_W-1:0] MISS_SAT = {MISS_W{1'b1}};

    state_t            state_q, state_d;
    logic [TW-1:0]     cmp_q, cmp_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              reached;
    logic              hit;
    logic              reload;

    iob_timer_alarm_cmp #(
        .WIDTH (TW)
    ) u_cmp (
        .time_val (time_i),
        .cmp_val  (cmp_q),
        .reached  (reached)
    );

    assign hit    = (state_q == StArmed) && en_i && reached;
    // A zero period would fire every cycle, so it degrades to one-shot.
    assign reload = periodic_i && (period_i != '0);

    // Next-state: compare load/reload, FSM, pending flag and miss counter.
    always_comb begin
        state_d   = state_q;
        cmp_d     = cmp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        miss_d    = miss_q;

        if (cke_i) begin
            if (cmp_lo_we_i) begin
                shadow_d = cmp_lo_i;
            end

            // A software commit overrides any simultaneous periodic reload.
            if (cmp_hi_we_i) begin
                cmp_d = {cmp_hi_i, (cmp_lo_we_i ? cmp_lo_i : shadow_q)};
            end else if (hit && reload) begin
                cmp_d = cmp_q + period_i;
            end

            if (!en_i) begin
                state_d = StIdle;
            end else if (cmp_hi_we_i) begin
                state_d = StArmed;
            end else if (hit && !reload) begin
                state_d = StFired;
            end

            // Set wins over acknowledge.
            if (hit) begin
                pending_d = 1'b1;
            end else if (ack_i) begin
                pending_d = 1'b0;
            end

            if (hit && pending_q && !ack_i) begin
                if (miss_q != MISS_SAT) begin
                    miss_d = miss_q + 1'b1;
                end
            end else if (ack_i && pending_q && !hit) begin
                miss_d = '0;
            end
        end
    end

    // State registers with synchronous reset that overrides the clock enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cmp_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmp_q     <= cmp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
        end
    end

    assign irq_o      = pending_q;
    assign armed_o    = (state_q == StArmed);
    assign cmp_o      = cmp_q;
    assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Directed bench for iob_timer_alarm; a second instance with MISS_W=2 checks saturation.
module tb_iob_timer_alarm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic [63:0] tm;
    logic [31:0] cmp_lo;
    logic        cmp_lo_we;
    logic [31:0] cmp_hi;
    logic        cmp_hi_we;
    logic [63:0] period;
    logic        periodic;
    logic        en;
    logic        ack;

    logic        irq, armed;
    logic [63:0] cmpo;
    logic [7:0]  miss;
    logic        irq2, armed2;
    logic [63:0] cmpo2;
    logic [1:0]  miss2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iob_timer_alarm #(.DATA_W(32), .MISS_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cke_i       (cke),
        .time_i      (tm),
        .cmp_lo_i    (cmp_lo),
        .cmp_lo_we_i (cmp_lo_we),
        .cmp_hi_i    (cmp_hi),
        .cmp_hi_we_i (cmp_hi_we),
        .period_i    (period),
        .periodic_i  (periodic),
        .en_i        (en),
        .ack_i       (ack),
        .irq_o       (irq),
        .armed_o     (armed),
        .cmp_o       (cmpo),
        .miss_cnt_o  (miss)
    );

    iob_timer_alarm #(.DATA_W(32), .MISS_W(2)) dut2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .cke_i       (cke),
        .time_i      (tm),
        .cmp_lo_i    (cmp_lo),
        .cmp_lo_we_i (cmp_lo_we),
        .cmp_hi_i    (cmp_hi),
        .cmp_hi_we_i (cmp_hi_we),
        .period_i    (period),
        .periodic_i  (periodic),
        .en_i        (en),
        .ack_i       (ack),
        .irq_o       (irq2),
        .armed_o     (armed2),
        .cmp_o       (cmpo2),
        .miss_cnt_o  (miss2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cke = 1'b1; tm = '0; cmp_lo = '0; cmp_lo_we = 1'b0; cmp_hi = '0; cmp_hi_we = 1'b0;
        period = '0; periodic = 1'b0; en = 1'b0; ack = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic commit_both(input logic [63:0] v);
        cmp_lo = v[31:0]; cmp_hi = v[63:32];
        cmp_lo_we = 1'b1; cmp_hi_we = 1'b1;
        step();
        cmp_lo_we = 1'b0; cmp_hi_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // Reset must apply even with the clock enable low.
        cke = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; cke = 1'b1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %h want 0", irq); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got %h want 0", armed); end
        checks++; if (cmpo !== 64'h0) begin failures++; $display("FAIL reset_cmp got %h want 0", cmpo); end
        checks++; if (miss !== 8'h0) begin failures++; $display("FAIL reset_miss got %h want 0", miss); end
        checks++; if (miss2 !== 2'h0) begin failures++; $display("FAIL reset_miss2 got %h want 0", miss2); end
    endtask

    task automatic test_oneshot();
        do_reset();
        en = 1'b1;
        cmp_lo = 32'h10; cmp_lo_we = 1'b1;
        step();
        cmp_lo_we = 1'b0;
        cmp_lo = 32'hDEAD_BEEF;
        cmp_hi = 32'h0; cmp_hi_we = 1'b1;
        step();
        cmp_hi_we = 1'b0;
        checks++; if (cmpo !== 64'h10) begin failures++; $display("FAIL oneshot_cmp got %h want 10", cmpo); end
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL oneshot_armed got %h want 1", armed); end
        for (int k = 0; k <= 16; k++) begin
            tm = 64'(k);
            step();
            if (k == 15) begin
                checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_early got %h want 0", irq); end
            end
        end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_fire got %h want 1", irq); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL oneshot_fired_state got %h want 0", armed); end
        tm = 64'h11; ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_ack got %h want 0", irq); end
        for (int k = 18; k <= 32; k++) begin
            tm = 64'(k);
            step();
        end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_nofire got %h want 0", irq); end
        checks++; if (miss !== 8'h0) begin failures++; $display("FAIL oneshot_miss got %h want 0", miss); end
    endtask

    task automatic test_periodic_wrap();
        do_reset();
        en = 1'b1; periodic = 1'b1; period = 64'h20;
        tm = 64'hFFFF_FFFF_FFFF_FFE0;
        commit_both(64'hFFFF_FFFF_FFFF_FFF0);
        tm = 64'hFFFF_FFFF_FFFF_FFE8;
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL wrap_early got %h want 0", irq); end
        tm = 64'hFFFF_FFFF_FFFF_FFF0;
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL wrap_fire1 got %h want 1", irq); end
        checks++; if (cmpo !== 64'h10) begin failures++; $display("FAIL wrap_reload got %h want 10", cmpo); end
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL wrap_armed got %h want 1", armed); end
        tm = 64'hFFFF_FFFF_FFFF_FFF8; ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL wrap_ack got %h want 0", irq); end
        tm = 64'h0;
        step();
        tm = 64'h8;
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL wrap_premature got %h want 0", irq); end
        tm = 64'h10;
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL wrap_fire2 got %h want 1", irq); end
        checks++; if (cmpo !== 64'h30) begin failures++; $display("FAIL wrap_reload2 got %h want 30", cmpo); end
    endtask

    task automatic test_past_compare();
        do_reset();
        en = 1'b1;
        tm = 64'h1000;
        commit_both(64'h500);
        checks++; if (cmpo !== 64'h500) begin failures++; $display("FAIL past_cmp got %h want 500", cmpo); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL past_irq_early got %h want 0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL past_fire got %h want 1", irq); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL past_fired_state got %h want 0", armed); end
    endtask

    task automatic test_missed();
        do_reset();
        en = 1'b1; periodic = 1'b1; period = 64'h4;
        commit_both(64'h8);
        for (int k = 0; k <= 8; k++) begin
            tm = 64'(k);
            step();
            if (k == 7) begin
                checks++; if (irq !== 1'b0) begin failures++; $display("FAIL miss_early got %h want 0", irq); end
            end
        end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL miss_first got %h want 1", irq); end
        checks++; if (miss !== 8'h0) begin failures++; $display("FAIL miss_first_cnt got %h want 0", miss); end
        // Hits at 12,16,...,44 while pending: nine misses.
        for (int k = 9; k <= 44; k++) begin
            tm = 64'(k);
            step();
        end
        checks++; if (miss !== 8'd9) begin failures++; $display("FAIL miss_count got %0d want 9", miss); end
        checks++; if (miss2 !== 2'd3) begin failures++; $display("FAIL miss_sat got %0d want 3", miss2); end
        checks++; if (cmpo !== 64'd48) begin failures++; $display("FAIL miss_cmp got %0d want 48", cmpo); end
        tm = 64'd45; ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL miss_ack_irq got %h want 0", irq); end
        checks++; if (miss !== 8'h0) begin failures++; $display("FAIL miss_ack_cnt got %0d want 0", miss); end
        checks++; if (miss2 !== 2'h0) begin failures++; $display("FAIL miss_ack_cnt2 got %0d want 0", miss2); end
    endtask

    task automatic test_hit_with_ack();
        // Continues from test_missed: cmp=48, pending clear.
        tm = 64'd48;
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL coinc_fire got %h want 1", irq); end
        tm = 64'd52;
        step();
        checks++; if (miss !== 8'd1) begin failures++; $display("FAIL coinc_miss1 got %0d want 1", miss); end
        tm = 64'd56; ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL coinc_irq got %h want 1", irq); end
        checks++; if (miss !== 8'd1) begin failures++; $display("FAIL coinc_miss_hold got %0d want 1", miss); end
        tm = 64'd57; ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL coinc_ack_irq got %h want 0", irq); end
        checks++; if (miss !== 8'd0) begin failures++; $display("FAIL coinc_ack_miss got %0d want 0", miss); end
    endtask

    task automatic test_reset_armed();
        do_reset();
        en = 1'b1;
        commit_both(64'h20);
        tm = 64'h1E;
        step();
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL rstarm_armed got %h want 1", armed); end
        tm = 64'h1F; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstarm_irq got %h want 0", irq); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rstarm_armed_clr got %h want 0", armed); end
        checks++; if (cmpo !== 64'h0) begin failures++; $display("FAIL rstarm_cmp got %h want 0", cmpo); end
        for (int k = 32; k <= 48; k++) begin
            tm = 64'(k);
            step();
        end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstarm_nofire got %h want 0", irq); end
    endtask

    task automatic test_cke();
        do_reset();
        en = 1'b1;
        commit_both(64'h20);
        tm = 64'h1F;
        step();
        cke = 1'b0;
        tm = 64'h20;
        step();
        tm = 64'h21;
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cke_hold_irq got %h want 0", irq); end
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL cke_hold_armed got %h want 1", armed); end
        cke = 1'b1;
        tm = 64'h22;
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL cke_resume_fire got %h want 1", irq); end
        checks++; if (armed2 !== 1'b0) begin failures++; $display("FAIL cke_fired2 got %h want 0", armed2); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic_wrap();
        test_past_compare();
        test_missed();
        test_hit_with_ack();
        test_reset_armed();
        test_cke();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
